// File: rtl/fpu_div_seq_pkg.sv
// Shared FPU types and helpers: divider FSM states, unpacked operand view,
// exponent bias and the canonical quiet NaN.
package pa_fpu;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_NORM = 2'd1,
    DIV_DIV  = 2'd2,
    DIV_RND  = 2'd3
  } e_div_state;

  // Unpacked fields are sized for the widest supported format; users slice.
  localparam int UNP_EXP_W = 16;
  localparam int UNP_MAN_W = 64;

  typedef struct packed {
    logic                        sign;
    logic signed [UNP_EXP_W-1:0] exp;
    logic [UNP_MAN_W-1:0]        mant;
    logic                        is_zero;
    logic                        is_inf;
    logic                        is_nan;
    logic                        is_sub;
  } st_fp_unpacked;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Sign 0, all-ones exponent, only the top fraction bit set.
  function automatic logic [63:0] qnan_word(input int exp_w, input int man_w);
    logic [63:0] ones_e;
    ones_e = (64'd1 << exp_w) - 64'd1;
    return (ones_e << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; an all-zero input returns WIDTH.
module fpu_lzc #(
  parameter  int WIDTH = 24,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] din,
  output logic [CNT_W-1:0] count
);

  always_comb begin
    count = CNT_W'(WIDTH);
    // Ascending scan so the most significant set bit is the last to write.
    for (int i = 0; i < WIDTH; i++) begin
      if (din[i]) count = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fpu_div_seq.sv
// Sequential IEEE-754 divider: restoring radix-2 division, one quotient bit
// per clock, round-to-nearest-even, subnormal inputs and outputs.
module fpu_div_seq
  import pa_fpu::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         start,
  input  logic [W-1:0] a_operand,
  input  logic [W-1:0] b_operand,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] ieee_packet_out,
  output logic         invalid,
  output logic         div_by_zero,
  output e_div_state   fsm_state
);

  localparam int M   = MAN_W + 1;
  localparam int Q   = MAN_W + 3;
  localparam int XW  = EXP_W + 2;
  localparam int LZW = $clog2(M + 1);
  localparam int CW  = $clog2(Q);
  localparam logic [W-1:0]          QNAN     = W'(qnan_word(EXP_W, MAN_W));
  localparam logic signed [XW-1:0]  EXP_ONE  = XW'(1);
  localparam logic signed [XW-1:0]  EXP_INF  = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0]  SH_MAX   = XW'(Q + 1);
  localparam logic [CW-1:0]         CNT_LAST = CW'(Q - 1);

  // Handshake: start is taken only in IDLE when done is low (that edge is the
  // accept edge, operands captured there); busy stays high from accept through
  // the single-cycle done pulse; results and flags hold until the next done.

  e_div_state state, state_nxt;
  logic       accept;

  logic [W-1:0]           a_q, b_q;
  logic [M:0]             rem_q;
  logic [M-1:0]           div_q;
  logic [Q-1:0]           quo_q;
  logic [CW-1:0]          cnt_q;
  logic signed [XW-1:0]   exp_q;
  logic                   sign_q;
  logic                   spec_q, spec_inv_q, spec_dbz_q;
  logic [W-1:0]           spec_res_q;

  logic [LZW-1:0] lz_a, lz_b;
  st_fp_unpacked  ua, ub;
  logic           res_sign, a_lt;
  int             e_div;
  logic           spec_hit, spec_inv, spec_dbz;
  logic [W-1:0]   spec_res;

  logic           ge;
  logic [M-1:0]   rem_sub;

  logic signed [XW-1:0]   sh;
  logic [Q-1:0]           q_sh;
  logic                   lost, g_bit, r_bit, s_bit, rup;
  logic [EXP_W-1:0]       ef;
  logic [EXP_W+MAN_W-1:0] mag;
  logic [W-1:0]           rnd_res;

  assign accept    = (state == DIV_IDLE) && start && !done;
  assign fsm_state = state;

  fpu_lzc #(.WIDTH(M)) u_lzc_a (.din({1'b0, a_q[MAN_W-1:0]}), .count(lz_a));
  fpu_lzc #(.WIDTH(M)) u_lzc_b (.din({1'b0, b_q[MAN_W-1:0]}), .count(lz_b));

  function automatic st_fp_unpacked unpack(input logic [W-1:0] x, input logic [LZW-1:0] lz);
    st_fp_unpacked    u;
    logic [EXP_W-1:0] fe;
    logic [MAN_W-1:0] fr;
    fe = x[W-2:MAN_W];
    fr = x[MAN_W-1:0];
    u = '0;
    u.sign    = x[W-1];
    u.is_nan  = (&fe) && (|fr);
    u.is_inf  = (&fe) && !(|fr);
    u.is_zero = !(|fe) && !(|fr);
    u.is_sub  = !(|fe) && (|fr);
    // Subnormals are normalised so every finite operand has its hidden bit set.
    if (u.is_sub) begin
      u.mant = UNP_MAN_W'({1'b0, fr}) << lz;
      u.exp  = UNP_EXP_W'(1) - UNP_EXP_W'(lz);
    end else begin
      u.mant = UNP_MAN_W'({1'b1, fr});
      u.exp  = UNP_EXP_W'(fe);
    end
    return u;
  endfunction

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= DIV_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE: if (accept) state_nxt = DIV_NORM;
      DIV_NORM: state_nxt = spec_hit ? DIV_RND : DIV_DIV;
      DIV_DIV:  if (cnt_q == CNT_LAST) state_nxt = DIV_RND;
      DIV_RND:  state_nxt = DIV_IDLE;
      default:  state_nxt = DIV_IDLE;
    endcase
  end

  always_comb begin
    ua       = unpack(a_q, lz_a);
    ub       = unpack(b_q, lz_b);
    res_sign = a_q[W-1] ^ b_q[W-1];
    a_lt     = ua.mant < ub.mant;
    e_div    = int'(signed'(ua.exp)) - int'(signed'(ub.exp)) + bias(EXP_W) - (a_lt ? 1 : 0);
    spec_hit = 1'b1;
    spec_inv = 1'b0;
    spec_dbz = 1'b0;
    spec_res = '0;
    if (ua.is_nan || ub.is_nan) begin
      spec_res = QNAN;
      spec_inv = 1'b1;
    end else if ((ua.is_zero && ub.is_zero) || (ua.is_inf && ub.is_inf)) begin
      spec_res = QNAN;
      spec_inv = 1'b1;
    end else if (ua.is_inf) begin
      spec_res = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (ub.is_zero) begin
      spec_res = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      spec_dbz = 1'b1;
    end else if (ub.is_inf || ua.is_zero) begin
      spec_res = {res_sign, {(W-1){1'b0}}};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // After a subtract the partial remainder is below the divisor, so M bits hold it.
  assign ge      = rem_q >= {1'b0, div_q};
  assign rem_sub = ge ? M'(rem_q - {1'b0, div_q}) : rem_q[M-1:0];

  always_comb begin
    sh = EXP_ONE - exp_q;
    if (sh > SH_MAX) sh = SH_MAX;
    q_sh = quo_q;
    lost = 1'b0;
    ef   = exp_q[EXP_W-1:0];
    // Tiny results are denormalised first so rounding happens at the subnormal LSB.
    if (exp_q < EXP_ONE) begin
      q_sh = quo_q >> sh;
      lost = |(quo_q & ~({Q{1'b1}} << sh));
      ef   = '0;
    end
    g_bit = q_sh[1];
    r_bit = q_sh[0];
    s_bit = (|rem_q) | lost;
    rup   = g_bit & (r_bit | s_bit | q_sh[2]);
    mag   = {ef, q_sh[Q-2:2]} + (EXP_W+MAN_W)'(rup);
    if (exp_q >= EXP_INF) rnd_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else                  rnd_res = {sign_q, mag};
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      a_q             <= '0;
      b_q             <= '0;
      rem_q           <= '0;
      div_q           <= '0;
      quo_q           <= '0;
      cnt_q           <= '0;
      exp_q           <= '0;
      sign_q          <= 1'b0;
      spec_q          <= 1'b0;
      spec_inv_q      <= 1'b0;
      spec_dbz_q      <= 1'b0;
      spec_res_q      <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      ieee_packet_out <= '0;
      invalid         <= 1'b0;
      div_by_zero     <= 1'b0;
    end else begin
      if (done) begin
        done <= 1'b0;
        busy <= 1'b0;
      end
      case (state)
        DIV_IDLE: if (accept) begin
          a_q  <= a_operand;
          b_q  <= b_operand;
          busy <= 1'b1;
        end
        DIV_NORM: begin
          sign_q     <= res_sign;
          spec_q     <= spec_hit;
          spec_inv_q <= spec_inv;
          spec_dbz_q <= spec_dbz;
          spec_res_q <= spec_res;
          rem_q      <= a_lt ? (M+1)'(ua.mant << 1) : (M+1)'(ua.mant);
          div_q      <= M'(ub.mant);
          exp_q      <= XW'(e_div);
          quo_q      <= '0;
          cnt_q      <= '0;
        end
        DIV_DIV: begin
          rem_q <= {rem_sub, 1'b0};
          quo_q <= {quo_q[Q-2:0], ge};
          cnt_q <= cnt_q + CW'(1);
        end
        DIV_RND: begin
          ieee_packet_out <= spec_q ? spec_res_q : rnd_res;
          invalid         <= spec_inv_q;
          div_by_zero     <= spec_dbz_q;
          done            <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
